// File: rtl/food_placer_if.sv
// Handshake and lookup bundle between the food placer, the LFSR,
// the occupancy table and the game controller.
interface food_placer_if;
  logic [5:0] rnd;
  logic       req;
  logic       occ_rd;
  logic [4:0] occ_x;
  logic [4:0] occ_y;
  logic       occ_hit;
  logic [4:0] food_x;
  logic [4:0] food_y;
  logic       food_valid;
  logic       busy;
  logic       done;
  logic       fail;

  modport master (
    output rnd, req, occ_hit,
    input  occ_rd, occ_x, occ_y, food_x, food_y, food_valid, busy, done, fail
  );

  modport slave (
    input  rnd, req, occ_hit,
    output occ_rd, occ_x, occ_y, food_x, food_y, food_valid, busy, done, fail
  );
endinterface

// File: rtl/food_placer.sv
// Chooses a free cell for the next food item: random candidates from the
// LFSR first, then a linear scan of the board once the retry budget is spent.
module food_placer #(
  parameter int GRID_W    = 32,
  parameter int GRID_H    = 24,
  parameter int MAX_TRIES = 8
) (
  input  logic          clk,
  input  logic          reset,
  food_placer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_X,
    ST_GET_Y,
    ST_QUERY,
    ST_EVAL,
    ST_PLACE,
    ST_FAIL
  } state_t;

  localparam logic [5:0]  GRID_W6    = 6'(GRID_W);
  localparam logic [5:0]  GRID_H6    = 6'(GRID_H);
  localparam logic [4:0]  X_LAST     = 5'(GRID_W - 1);
  localparam logic [4:0]  Y_LAST     = 5'(GRID_H - 1);
  localparam logic [3:0]  MAX_T      = 4'(MAX_TRIES);
  localparam logic [10:0] CELL_COUNT = 11'(GRID_W * GRID_H);

  state_t      state_q, state_d;
  logic [4:0]  candX_q, candX_d;
  logic [4:0]  candY_q, candY_d;
  logic [3:0]  tries_q, tries_d;
  logic        scanMode_q, scanMode_d;
  logic [10:0] scanCnt_q, scanCnt_d;
  logic [4:0]  foodX_q, foodX_d;
  logic [4:0]  foodY_q, foodY_d;
  logic        foodValid_q, foodValid_d;
  logic [4:0]  occX_q, occX_d;
  logic [4:0]  occY_q, occY_d;
  logic        occRd_q, occRd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fail_q, fail_d;

  logic [4:0]  advX, advY;
  logic [5:0]  rndLow;
  logic        unusedRnd;

  assign rndLow    = {1'b0, bus.rnd[4:0]};
  assign unusedRnd = bus.rnd[5];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      candX_q     <= '0;
      candY_q     <= '0;
      tries_q     <= '0;
      scanMode_q  <= 1'b0;
      scanCnt_q   <= '0;
      foodX_q     <= '0;
      foodY_q     <= '0;
      foodValid_q <= 1'b0;
      occX_q      <= '0;
      occY_q      <= '0;
      occRd_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      candX_q     <= candX_d;
      candY_q     <= candY_d;
      tries_q     <= tries_d;
      scanMode_q  <= scanMode_d;
      scanCnt_q   <= scanCnt_d;
      foodX_q     <= foodX_d;
      foodY_q     <= foodY_d;
      foodValid_q <= foodValid_d;
      occX_q      <= occX_d;
      occY_q      <= occY_d;
      occRd_q     <= occRd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
    end
  end

  // Row-major successor of the current candidate, wrapping at the board edges
  always_comb begin
    advX = candX_q + 5'd1;
    advY = candY_q;
    if (candX_q == X_LAST) begin
      advX = '0;
      advY = (candY_q == Y_LAST) ? 5'd0 : candY_q + 5'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    candX_d     = candX_q;
    candY_d     = candY_q;
    tries_d     = tries_q;
    scanMode_d  = scanMode_q;
    scanCnt_d   = scanCnt_q;
    foodX_d     = foodX_q;
    foodY_d     = foodY_q;
    foodValid_d = foodValid_q;
    occX_d      = occX_q;
    occY_d      = occY_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          state_d    = ST_GET_X;
          tries_d    = '0;
          scanMode_d = 1'b0;
          scanCnt_d  = '0;
          candX_d    = '0;
          candY_d    = '0;
        end
      end
      ST_GET_X: begin
        if (rndLow < GRID_W6) begin
          candX_d = bus.rnd[4:0];
          state_d = ST_GET_Y;
        end else begin
          tries_d = tries_q + 4'd1;
          if (tries_d >= MAX_T) begin
            scanMode_d = 1'b1;
            scanCnt_d  = '0;
            state_d    = ST_QUERY;
          end
        end
      end
      ST_GET_Y: begin
        if (rndLow < GRID_H6) begin
          candY_d = bus.rnd[4:0];
          state_d = ST_QUERY;
        end else begin
          tries_d = tries_q + 4'd1;
          if (tries_d >= MAX_T) begin
            scanMode_d = 1'b1;
            scanCnt_d  = '0;
            state_d    = ST_QUERY;
          end
        end
      end
      ST_QUERY: state_d = ST_EVAL;
      ST_EVAL: begin
        if (!bus.occ_hit) begin
          state_d = ST_PLACE;
        end else if (!scanMode_q) begin
          tries_d = tries_q + 4'd1;
          if (tries_d < MAX_T) begin
            state_d = ST_GET_X;
          end else begin
            scanMode_d = 1'b1;
            scanCnt_d  = '0;
            candX_d    = advX;
            candY_d    = advY;
            state_d    = ST_QUERY;
          end
        end else begin
          scanCnt_d = scanCnt_q + 11'd1;
          if (scanCnt_d == CELL_COUNT) begin
            state_d = ST_FAIL;
          end else begin
            candX_d = advX;
            candY_d = advY;
            state_d = ST_QUERY;
          end
        end
      end
      ST_PLACE: state_d = ST_IDLE;
      ST_FAIL:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered
    occRd_d = (state_d == ST_QUERY);
    done_d  = (state_d == ST_PLACE);
    fail_d  = (state_d == ST_FAIL);
    busy_d  = (state_d != ST_IDLE) && (state_d != ST_PLACE) && (state_d != ST_FAIL);
    if (occRd_d) begin
      occX_d = candX_d;
      occY_d = candY_d;
    end
    if (done_d) begin
      foodX_d     = candX_d;
      foodY_d     = candY_d;
      foodValid_d = 1'b1;
    end
    if (fail_d) begin
      foodValid_d = 1'b0;
    end
  end

  assign bus.occ_rd     = occRd_q;
  assign bus.occ_x      = occX_q;
  assign bus.occ_y      = occY_q;
  assign bus.food_x     = foodX_q;
  assign bus.food_y     = foodY_q;
  assign bus.food_valid = foodValid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.fail       = fail_q;

endmodule

// File: tb/tb_food_placer.sv
// Directed bench for food_placer on the default 32x24 board with 8 random tries.
module tb_food_placer;

  logic clk;
  logic reset;
  int   asserts;
  int   failures;
  int   occRdCount;
  int   doneCount;
  int   failCount;
  int   cycles;

  food_placer_if bus ();

  food_placer #(.GRID_W(32), .GRID_H(24), .MAX_TRIES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs for the coming edge, then sample just after it
  task automatic applyStimulus(input logic reqIn, input logic [5:0] rndIn, input logic hitIn);
    bus.req     = reqIn;
    bus.rnd     = rndIn;
    bus.occ_hit = hitIn;
    @(posedge clk);
    #1;
    if (bus.occ_rd === 1'b1) occRdCount++;
    if (bus.done === 1'b1) doneCount++;
    if (bus.fail === 1'b1) failCount++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearCounts();
    occRdCount = 0;
    doneCount  = 0;
    failCount  = 0;
  endtask

  initial begin
    asserts  = 0;
    failures = 0;
    clearCounts();
    bus.req     = 1'b0;
    bus.rnd     = '0;
    bus.occ_hit = 1'b0;
    reset       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_state", {bus.food_valid, bus.busy, bus.done, bus.fail, bus.occ_rd}, 0);
    checkOutput("rst_coords", {bus.food_x, bus.food_y, bus.occ_x, bus.occ_y}, 0);
    reset = 1'b0;

    $display("[TB] best case placement");
    applyStimulus(1'b1, 6'd0, 1'b0);
    checkOutput("best_busy_c1", bus.busy, 1);
    applyStimulus(1'b0, 6'd5, 1'b0);
    applyStimulus(1'b0, 6'd7, 1'b0);
    checkOutput("best_query_c3", {bus.occ_rd, bus.busy, bus.occ_x, bus.occ_y}, {2'b11, 5'd5, 5'd7});
    applyStimulus(1'b0, 6'd0, 1'b0);
    checkOutput("best_eval_c4", {bus.occ_rd, bus.busy, bus.done}, 3'b010);
    applyStimulus(1'b0, 6'd0, 1'b0);
    checkOutput("best_place_c5", {bus.done, bus.busy, bus.food_valid, bus.food_x, bus.food_y},
                {3'b101, 5'd5, 5'd7});
    applyStimulus(1'b0, 6'd0, 1'b0);
    checkOutput("best_done_drop", {bus.done, bus.busy}, 0);

    $display("[TB] out-of-range row");
    applyStimulus(1'b1, 6'd0, 1'b0);
    applyStimulus(1'b0, 6'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 6'd30, 1'b0);
      checkOutput("row_reject", {bus.busy, bus.occ_rd}, 2'b10);
    end
    applyStimulus(1'b0, 6'd10, 1'b0);
    checkOutput("row_query", {bus.occ_rd, bus.occ_x, bus.occ_y}, {1'b1, 5'd3, 5'd10});
    applyStimulus(1'b0, 6'd0, 1'b0);
    applyStimulus(1'b0, 6'd0, 1'b0);
    checkOutput("row_place", {bus.done, bus.food_x, bus.food_y}, {1'b1, 5'd3, 5'd10});
    applyStimulus(1'b0, 6'd0, 1'b0);

    $display("[TB] collision retry");
    clearCounts();
    applyStimulus(1'b1, 6'd0, 1'b0);
    applyStimulus(1'b0, 6'd4, 1'b0);
    applyStimulus(1'b0, 6'd6, 1'b0);
    checkOutput("coll_q1", {bus.occ_x, bus.occ_y}, {5'd4, 5'd6});
    applyStimulus(1'b0, 6'd0, 1'b0);
    applyStimulus(1'b0, 6'd0, 1'b1);
    checkOutput("coll_retry_c5", {bus.busy, bus.done}, 2'b10);
    applyStimulus(1'b0, 6'd9, 1'b0);
    applyStimulus(1'b0, 6'd2, 1'b0);
    checkOutput("coll_q2", {bus.occ_rd, bus.occ_x, bus.occ_y}, {1'b1, 5'd9, 5'd2});
    applyStimulus(1'b0, 6'd0, 1'b0);
    checkOutput("coll_no_early_done", bus.done, 0);
    applyStimulus(1'b0, 6'd0, 1'b0);
    checkOutput("coll_place_c9", {bus.done, bus.food_x, bus.food_y}, {1'b1, 5'd9, 5'd2});
    checkOutput("coll_occrd_pulses", occRdCount, 2);
    applyStimulus(1'b0, 6'd0, 1'b0);

    $display("[TB] full board");
    clearCounts();
    applyStimulus(1'b1, 6'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 6'd1, 1'b1);
      applyStimulus(1'b0, 6'd1, 1'b1);
      applyStimulus(1'b0, 6'd0, 1'b1);
      applyStimulus(1'b0, 6'd0, 1'b1);
    end
    checkOutput("full_scan_start", {bus.occ_rd, bus.occ_x, bus.occ_y}, {1'b1, 5'd2, 5'd1});
    cycles = 0;
    while (bus.fail !== 1'b1 && cycles < 4000) begin
      applyStimulus(1'b0, 6'd0, 1'b1);
      cycles++;
    end
    checkOutput("full_fail_seen", bus.fail, 1);
    checkOutput("full_queries", occRdCount, 776);
    checkOutput("full_outputs", {bus.food_valid, bus.busy, bus.food_x, bus.food_y},
                {2'b00, 5'd9, 5'd2});
    checkOutput("full_no_done", doneCount, 0);
    applyStimulus(1'b0, 6'd0, 1'b0);
    checkOutput("full_fail_drop", {bus.fail, bus.busy}, 0);

    $display("[TB] scan fallback");
    clearCounts();
    applyStimulus(1'b1, 6'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, (i == 7) ? 6'd31 : 6'(i), 1'b0);
      applyStimulus(1'b0, (i == 7) ? 6'd23 : 6'(i), 1'b0);
      applyStimulus(1'b0, 6'd0, 1'b0);
      applyStimulus(1'b0, 6'd0, 1'b1);
    end
    checkOutput("scan_wrap_query", {bus.occ_rd, bus.occ_x, bus.occ_y}, {1'b1, 5'd0, 5'd0});
    applyStimulus(1'b0, 6'd0, 1'b0);
    applyStimulus(1'b0, 6'd0, 1'b0);
    checkOutput("scan_place", {bus.done, bus.food_valid, bus.food_x, bus.food_y}, {2'b11, 10'd0});
    checkOutput("scan_queries", occRdCount, 9);
    applyStimulus(1'b0, 6'd0, 1'b0);

    $display("[TB] req while busy");
    clearCounts();
    applyStimulus(1'b1, 6'd0, 1'b0);
    applyStimulus(1'b1, 6'd12, 1'b0);
    applyStimulus(1'b1, 6'd20, 1'b0);
    applyStimulus(1'b1, 6'd0, 1'b0);
    applyStimulus(1'b0, 6'd0, 1'b0);
    checkOutput("busy_req_place", {bus.done, bus.food_x, bus.food_y}, {1'b1, 5'd12, 5'd20});
    applyStimulus(1'b0, 6'd0, 1'b0);
    applyStimulus(1'b0, 6'd0, 1'b0);
    checkOutput("busy_req_single", {doneCount[7:0], occRdCount[7:0], 7'd0, bus.busy},
                {8'd1, 8'd1, 8'd0});

    $display("[TB] reset during EVAL");
    clearCounts();
    applyStimulus(1'b1, 6'd0, 1'b0);
    applyStimulus(1'b0, 6'd14, 1'b0);
    applyStimulus(1'b0, 6'd15, 1'b0);
    applyStimulus(1'b0, 6'd0, 1'b0);
    checkOutput("rst_eval_busy", bus.busy, 1);
    reset = 1'b1;
    #1;
    checkOutput("rst_eval_flags", {bus.food_valid, bus.busy, bus.done, bus.fail, bus.occ_rd}, 0);
    checkOutput("rst_eval_coords", {bus.food_x, bus.food_y, bus.occ_x, bus.occ_y}, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 6'd0, 1'b0);
    checkOutput("rst_eval_no_done", {doneCount[7:0], failCount[7:0], 7'd0, bus.busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
